// File: rtl/clock_pkg.sv
// Shared clock-digit types, mode encoding and BCD digit limits.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] MODE_SET        = 2'b01;
    localparam bcd_t       SEC_TENS_MAX    = 4'd5;
    localparam bcd_t       MIN_TENS_MAX    = 4'd5;
    localparam bcd_t       UNITS_MAX       = 4'd9;
    localparam bcd_t       HOUR_TENS_MAX   = 4'd2;
    localparam bcd_t       HOUR_WRAP_UNITS = 4'd3;

    // True when the six digits form a legal 24-hour time.
    function automatic logic load_valid(bcd_t h1, bcd_t h2, bcd_t m1, bcd_t m2,
                                        bcd_t s1, bcd_t s2);
        return (m1 <= MIN_TENS_MAX) && (m2 <= UNITS_MAX) &&
               (s1 <= SEC_TENS_MAX) && (s2 <= UNITS_MAX) &&
               (h1 <= HOUR_TENS_MAX) && (h2 <= UNITS_MAX) &&
               !((h1 == HOUR_TENS_MAX) && (h2 > HOUR_WRAP_UNITS));
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Setter-to-timekeeper bundle: mode and loaded digits in, running digits and event pulses out.
// Latency: n/a (wires only).
// Backpressure: none; the time stream is free-running.
interface time_counter_if;
    import clock_pkg::*;

    logic [1:0] set_mode;
    bcd_t       set_hour1, set_hour2, set_min1, set_min2, set_sec1, set_sec2;
    bcd_t       hour1, hour2, min1, min2, sec1, sec2;
    logic       sec_tick;
    logic       day_wrap;
    logic       load_err;
    logic       chime;

    modport slave (
        input  set_mode, set_hour1, set_hour2, set_min1, set_min2, set_sec1, set_sec2,
        output hour1, hour2, min1, min2, sec1, sec2, sec_tick, day_wrap, load_err, chime
    );

    modport master (
        output set_mode, set_hour1, set_hour2, set_min1, set_min2, set_sec1, set_sec2,
        input  hour1, hour2, min1, min2, sec1, sec2, sec_tick, day_wrap, load_err, chime
    );

endinterface

// File: rtl/time_counter_tick.sv
// Prescaler: counts 0..CLK_HZ-1 and wraps; tick is high while the count sits on CLK_HZ-1.
// Latency: tick is combinational from the count register; clr takes effect on the next edge.
// Backpressure: none; clr holds the count at zero.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD timekeeper; captures setter digits on set-mode exit. Optional hourly chime: TIME_COUNTER_CHIME_EN.
// Latency: all outputs registered, one cycle after the tick or load condition.
// Backpressure: none; set mode (2'b01) freezes the digits and holds the prescaler at zero.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    time_counter_if.slave tc
);

    logic [1:0] mode_q, mode_d;
    bcd_t       hour1_q, hour2_q, min1_q, min2_q, sec1_q, sec2_q;
    bcd_t       hour1_d, hour2_d, min1_d, min2_d, sec1_d, sec2_d;
    bcd_t       inc_hour1, inc_hour2, inc_min1, inc_min2, inc_sec1, inc_sec2;
    logic       sec_tick_q, sec_tick_d;
    logic       day_wrap_q, day_wrap_d;
    logic       load_err_q, load_err_d;
    logic       in_set, load, load_ok, tick, inc;
    logic       c_s2, c_s1, c_m2, c_hr, c_day, c_h2;

    assign in_set  = (tc.set_mode == MODE_SET);
    assign load    = (mode_q == MODE_SET) && !in_set;
    assign load_ok = load_valid(tc.set_hour1, tc.set_hour2, tc.set_min1,
                                tc.set_min2, tc.set_sec1, tc.set_sec2);
    // A load cycle never also advances time, even if the prescaler happens to be on its last count.
    assign inc     = tick && !in_set && !load;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_set || load),
        .tick  (tick)
    );

    // Carry out of each digit position; c_hr means the minutes and seconds roll to 00:00.
    assign c_s2  = (sec2_q == UNITS_MAX);
    assign c_s1  = c_s2 && (sec1_q == SEC_TENS_MAX);
    assign c_m2  = c_s1 && (min2_q == UNITS_MAX);
    assign c_hr  = c_m2 && (min1_q == MIN_TENS_MAX);
    assign c_day = c_hr && (hour1_q == HOUR_TENS_MAX) && (hour2_q == HOUR_WRAP_UNITS);
    assign c_h2  = c_hr && (hour2_q == UNITS_MAX);

    assign inc_sec2  = c_s2 ? '0 : sec2_q + 4'd1;
    assign inc_sec1  = c_s1 ? '0 : (c_s2 ? sec1_q + 4'd1 : sec1_q);
    assign inc_min2  = c_m2 ? '0 : (c_s1 ? min2_q + 4'd1 : min2_q);
    assign inc_min1  = c_hr ? '0 : (c_m2 ? min1_q + 4'd1 : min1_q);
    assign inc_hour2 = (c_day || c_h2) ? '0 : (c_hr ? hour2_q + 4'd1 : hour2_q);
    assign inc_hour1 = c_day ? '0 : (c_h2 ? hour1_q + 4'd1 : hour1_q);

    always_comb begin
        mode_d     = tc.set_mode;
        hour1_d    = hour1_q;
        hour2_d    = hour2_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        sec1_d     = sec1_q;
        sec2_d     = sec2_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                hour1_d = tc.set_hour1;
                hour2_d = tc.set_hour2;
                min1_d  = tc.set_min1;
                min2_d  = tc.set_min2;
                sec1_d  = tc.set_sec1;
                sec2_d  = tc.set_sec2;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc) begin
            hour1_d    = inc_hour1;
            hour2_d    = inc_hour2;
            min1_d     = inc_min1;
            min2_d     = inc_min2;
            sec1_d     = inc_sec1;
            sec2_d     = inc_sec2;
            sec_tick_d = 1'b1;
            day_wrap_d = c_day;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            hour1_q    <= '0;
            hour2_q    <= '0;
            min1_q     <= '0;
            min2_q     <= '0;
            sec1_q     <= '0;
            sec2_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            hour1_q    <= hour1_d;
            hour2_q    <= hour2_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            sec1_q     <= sec1_d;
            sec2_q     <= sec2_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef TIME_COUNTER_CHIME_EN
    logic chime_q, chime_d;

    // Only an increment can chime; loading xx:00:00 does not.
    assign chime_d = inc && c_hr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= chime_d;
        end
    end

    assign tc.chime = chime_q;
`else
    assign tc.chime = 1'b0;
`endif

    assign tc.hour1    = hour1_q;
    assign tc.hour2    = hour2_q;
    assign tc.min1     = min1_q;
    assign tc.min2     = min2_q;
    assign tc.sec1     = sec1_q;
    assign tc.sec2     = sec2_q;
    assign tc.sec_tick = sec_tick_q;
    assign tc.day_wrap = day_wrap_q;
    assign tc.load_err = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter at CLK_HZ=4: hand-written sequences, a load table and random traffic,
// all checked every cycle against a seconds-of-day reference model.
module tb_time_counter;
    import clock_pkg::*;

    localparam int HZ = 4;
    localparam int CW = 3;
`ifdef TIME_COUNTER_CHIME_EN
    localparam logic CH = 1'b1;
`else
    localparam logic CH = 1'b0;
`endif

    typedef struct {
        logic [23:0] set_val;
        logic        err;
        logic [23:0] exp_time;
    } load_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    time_counter_if tc();

    time_counter #(
        .CLK_HZ (HZ),
        .CNT_W  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (tc)
    );

    // Reference model state: time as seconds since midnight.
    int         m_secs;
    int         m_pcnt;
    logic [1:0] m_mprev;
    logic       m_tick, m_wrap, m_err, m_chime;

    function automatic logic [23:0] secs_bcd(int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_secs(logic [23:0] b);
        return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
               (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
               (int'(b[7:4]) * 10 + int'(b[3:0]));
    endfunction

    function automatic logic ref_valid(logic [23:0] b);
        return (int'(b[19:16]) <= 9) && (int'(b[15:12]) <= 5) && (int'(b[11:8]) <= 9) &&
               (int'(b[7:4]) <= 5) && (int'(b[3:0]) <= 9) &&
               (int'(b[23:20]) * 10 + int'(b[19:16]) <= 23);
    endfunction

    function automatic logic [27:0] dut_vec();
        return {tc.hour1, tc.hour2, tc.min1, tc.min2, tc.sec1, tc.sec2,
                tc.sec_tick, tc.day_wrap, tc.load_err, tc.chime};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {secs_bcd(m_secs), m_tick, m_wrap, m_err, m_chime};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_pcnt = 0; m_mprev = 2'b00;
        m_tick = 0; m_wrap = 0; m_err = 0; m_chime = 0;
    endtask

    task automatic model_step();
        logic [23:0] sv;
        sv = {tc.set_hour1, tc.set_hour2, tc.set_min1, tc.set_min2, tc.set_sec1, tc.set_sec2};
        m_tick = 0; m_wrap = 0; m_err = 0; m_chime = 0;
        if (m_mprev == 2'b01 && tc.set_mode != 2'b01) begin
            m_pcnt = 0;
            if (ref_valid(sv)) m_secs = bcd_secs(sv);
            else               m_err = 1;
        end else if (tc.set_mode == 2'b01) begin
            m_pcnt = 0;
        end else if (m_pcnt == HZ - 1) begin
            m_pcnt  = 0;
            m_secs  = (m_secs + 1) % 86400;
            m_tick  = 1;
            m_wrap  = (m_secs == 0);
            m_chime = CH && (m_secs % 3600 == 0);
        end else begin
            m_pcnt++;
        end
        m_mprev = tc.set_mode;
    endtask

    task automatic check(string name, logic [27:0] act, logic [27:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_set(logic [1:0] mode, logic [23:0] b);
        tc.set_mode  = mode;
        tc.set_hour1 = b[23:20];
        tc.set_hour2 = b[19:16];
        tc.set_min1  = b[15:12];
        tc.set_min2  = b[11:8];
        tc.set_sec1  = b[7:4];
        tc.set_sec2  = b[3:0];
    endtask

    task automatic step(string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, dut_vec(), exp_vec());
    endtask

    task automatic run(int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step("run");
            if (tc.sec_tick) ticks++;
        end
    endtask

    task automatic do_load(logic [23:0] b, int hold);
        drive_set(2'b01, b);
        for (int i = 0; i < hold; i++) step("set_hold");
        drive_set(2'b00, b);
        step("load_edge");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_vec_t tbl[8];
        int        ticks;
        int        n;
        logic [1:0] mode;
        logic [23:0] sv;
        int        s;

        tbl[0] = '{24'h290000, 1'b1, 24'h000000};
        tbl[1] = '{24'h230000, 1'b0, 24'h230000};
        tbl[2] = '{24'h241010, 1'b1, 24'h230000};
        tbl[3] = '{24'h126000, 1'b1, 24'h230000};
        tbl[4] = '{24'h095959, 1'b0, 24'h095959};
        tbl[5] = '{24'h19595A, 1'b1, 24'h095959};
        tbl[6] = '{24'h200060, 1'b1, 24'h095959};
        tbl[7] = '{24'h000000, 1'b0, 24'h000000};

        // Reset state
        drive_set(2'b00, 24'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_vec(), 28'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First increment after 4 run cycles, then one every 4
        repeat (3) step("t1_pre");
        step("t1_first");
        check("t1_first_inc", dut_vec(), {24'h000001, 4'b1000});
        run(8, ticks);
        check("t1_tick_count", 28'(ticks), 28'd2);
        check("t1_time", {dut_vec()[27:4], 4'b0}, {24'h000003, 4'b0});

        // Day wrap
        do_load(24'h235958, 2);
        check("t2_load", dut_vec(), {24'h235958, 4'b0000});
        repeat (3) step("t2_a");
        step("t2_b");
        check("t2_235959", dut_vec(), {24'h235959, 4'b1000});
        repeat (3) step("t2_c");
        step("t2_d");
        check("t2_wrap", dut_vec(), {24'h000000, 1'b1, 1'b1, 1'b0, CH});
        step("t2_after");
        check("t2_wrap_pulse_end", {26'h0, tc.day_wrap, tc.chime}, 28'h0);

        // Load validation table
        for (int i = 0; i < 8; i++) begin
            do_load(tbl[i].set_val, 2);
            check($sformatf("t3_tbl%0d", i), dut_vec(), {tbl[i].exp_time, 2'b00, tbl[i].err, 1'b0});
        end

        // Long set mode freezes time, first increment exactly 4 cycles after load
        drive_set(2'b01, 24'h123456);
        run(20, ticks);
        check("t4_frozen_ticks", 28'(ticks), 28'd0);
        check("t4_frozen_time", {dut_vec()[27:4], 4'b0}, {24'h000000, 4'b0});
        drive_set(2'b00, 24'h123456);
        step("t4_load");
        n = 0;
        do begin
            step("t4_wait");
            n++;
        end while (!tc.sec_tick && n < 10);
        check("t4_first_inc_latency", 28'(n), 28'd4);
        check("t4_time", dut_vec(), {24'h123457, 4'b1000});

        // Set/load overlapping a pending tick: no increment
        repeat (3) step("t5_pre");
        drive_set(2'b01, 24'h222222);
        step("t5_set");
        check("t5_set_no_tick", dut_vec(), {24'h123457, 4'b0000});
        drive_set(2'b00, 24'h222222);
        step("t5_load");
        check("t5_load_wins", dut_vec(), {24'h222222, 4'b0000});

        // Async reset mid-count
        do_load(24'h123456, 2);
        repeat (2) step("t6_pre");
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", dut_vec(), 28'h0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (3) step("t6_post");
        step("t6_first");
        check("t6_resume", dut_vec(), {24'h000001, 4'b1000});

        // Random traffic against the model
        mode = 2'b00;
        sv = 24'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if (mode == 2'b01) begin
                    mode = 2'($urandom_range(0, 3));
                    if (mode == 2'b01) mode = 2'b00;
                end else begin
                    mode = 2'b01;
                    if ($urandom_range(0, 3) == 0) begin
                        sv = 24'($urandom);
                    end else begin
                        s = int'($urandom_range(0, 86399));
                        if ($urandom_range(0, 1) == 1)
                            s = int'($urandom_range(0, 23)) * 3600 + 3599 - int'($urandom_range(0, 2));
                        sv = secs_bcd(s);
                    end
                end
            end
            drive_set(mode, sv);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Running timekeeper stage directly downstream of the time-setting block.
- Captures the six BCD digits that block produces when set mode is exited.
- Advances them once per second in 24-hour format and drives the display digits.
- Holds time frozen while set mode (set_mode == 2'b01) is active.

Parameters:
- CLK_HZ, 100_000_000, clk frequency; the prescaler divides by this to make the 1 s tick (must be >= 2).
- CNT_W, 27, prescaler counter width; must satisfy 2^CNT_W >= CLK_HZ.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- set_mode  input  2  mode select; 2'b01 = setting in progress
- set_hour1  input  4  tens-of-hours from setter (BCD)
- set_hour2  input  4  units-of-hours from setter
- set_min1  input  4  tens-of-minutes from setter
- set_min2  input  4  units-of-minutes from setter
- set_sec1  input  4  tens-of-seconds from setter
- set_sec2  input  4  units-of-seconds from setter
- hour1, hour2, min1, min2, sec1, sec2  output  4 each  running time, BCD, registered
- sec_tick  output  1  one-cycle pulse on every time increment
- day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition
- load_err  output  1  one-cycle pulse when a load is rejected
- chime  output  1  hourly pulse (optional feature; otherwise tied 0)

Behaviour:
- Reset (rst_n low, async): all digits 0 (00:00:00), prescaler 0, mode_q 0, all pulses 0.
- mode_q is set_mode registered each cycle. load = (mode_q == 2'b01) && (set_mode != 2'b01), asserted for exactly one cycle.
- Set mode (set_mode == 2'b01):
  - Prescaler held at 0.
  - Digits hold their value; no sec_tick is generated.
- Run mode (set_mode != 2'b01):
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - tick = (prescaler == CLK_HZ-1).
  - The digits update on the edge where tick is true. sec_tick is registered on that same edge.
- Increment: BCD ripple.
  - sec2 9->0 carries into sec1; sec1 5->0 carries into min2; min2 9->0 carries into min1; min1 5->0 carries into the hour.
  - Hour: hour2 9->0 carries into hour1. 23 -> 00 asserts day_wrap.
  - No binary intermediate value is ever visible on the outputs.
- Load validation: the load is valid only if all of the following hold:
  - set_min1 <= 5, set_min2 <= 9, set_sec1 <= 5, set_sec2 <= 9;
  - set_hour1 <= 2, set_hour2 <= 9;
  - not (set_hour1 == 2 && set_hour2 > 3).
- Valid load: all six digits are captured on the load edge and the prescaler is cleared to 0. The first second after leaving set mode is therefore a full CLK_HZ cycles.
- Invalid load:
  - Digits keep their pre-set value and the prescaler is cleared.
  - load_err pulses one cycle, registered on the load edge.
- Simultaneous events:
  - load beats tick; no increment happens on the load cycle.
  - Reset beats everything, including mid-load.
- Latency: a digit change is visible 1 cycle after the qualifying edge condition.
- set_mode values 00, 10 and 11 all count normally.

Optional Feature:
- Macro: TIME_COUNTER_CHIME_EN.
- Defined: chime pulses one cycle, coincident with sec_tick, whenever the increment yields min == 00 and sec == 00. This includes day_wrap. A load of xx:00:00 does not chime.
- Undefined: no chime logic is generated and the chime port is driven constant 0.

Decomposition:
- Shared package clock_pkg holds:
  - MODE_SET = 2'b01;
  - digit limit constants SEC_TENS_MAX = 5, MIN_TENS_MAX = 5, UNITS_MAX = 9, HOUR_TENS_MAX = 2, HOUR_WRAP_UNITS = 3;
  - typedef bcd_t = logic [3:0].
- One sub-module, tick_gen: the prescaler with a clear input and the CLK_HZ/CNT_W parameters, producing tick.
- BCD carry chain and load validation stay in time_counter.

Test Plan:
1. Reset with CLK_HZ = 4 -> outputs 00:00:00; after 4 run cycles sec2 = 1 and sec_tick pulses once; every 4 cycles after that one further increment.
2. Load 23:59:58 (set_mode 01 -> 00) -> load edge shows 23:59:58; +4 cycles gives 23:59:59; +4 more gives 00:00:00 with day_wrap = 1 for one cycle (and chime when TIME_COUNTER_CHIME_EN is defined).
3. Load 29:00:00 -> load_err pulses, previous time retained; load 24:10:10 -> rejected; load 23:00:00 -> accepted, no error.
4. Hold set_mode = 01 for 20 cycles -> digits frozen, no sec_tick; on exit the first increment arrives exactly 4 cycles after the load edge.
5. Exit set mode on the cycle the prescaler would reach CLK_HZ-1 -> load wins, no increment on that edge.
6. Assert rst_n low mid-count at 12:34:56 -> outputs 00:00:00 immediately, no pulses; counting resumes from 0 after release.
